// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory-macro signals shared by mem_arbiter and its neighbours
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [3:0]  mem_w_enb;
  logic        mem_r_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  // the arbiter itself
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );

  // the pipeline ports plus the memory macro
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_r_data,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for a single-ported byte memory; `define MEM_ARB_DPRIO_EN for fixed data priority
module mem_arbiter #(
  parameter int ADDR_BITS = 10
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // highest byte address; a 4-byte access must end at or below it
  localparam logic [32:0] LIMIT = 33'((64'd1 << ADDR_BITS) - 64'd1);

  logic        i_oor;
  logic        d_oor;
  logic        d_is_read;
  logic        pick_d;
  logic        i_gnt;
  logic        d_gnt;

  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        i_err_q;
  logic        d_err_q;

  assign i_oor     = ({1'b0, bus.i_addr} + 33'd3) > LIMIT;
  assign d_oor     = ({1'b0, bus.d_addr} + 33'd3) > LIMIT;
  assign d_is_read = (bus.d_we == 4'b0000);

`ifdef MEM_ARB_DPRIO_EN
  always_comb begin
    pick_d = bus.d_req;
  end
`else
  logic last_q;

  // on a tie the port that lost the previous grant goes first
  always_comb begin
    pick_d = bus.d_req && (!bus.i_req || !last_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (d_gnt) begin
      last_q <= 1'b1;
    end else if (i_gnt) begin
      last_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!rst) begin
      d_gnt = pick_d;
      i_gnt = bus.i_req && !pick_d;
    end
  end

  // out-of-range grants keep the handshake but never touch the macro
  always_comb begin
    bus.mem_w_enb  = 4'b0000;
    bus.mem_r_enb  = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_w_data = 32'd0;
    if (i_gnt) begin
      bus.mem_addr   = bus.i_addr;
      bus.mem_w_data = bus.d_wdata;
      bus.mem_r_enb  = !i_oor;
    end else if (d_gnt) begin
      bus.mem_addr   = bus.d_addr;
      bus.mem_w_data = bus.d_wdata;
      bus.mem_r_enb  = !d_oor && d_is_read;
      bus.mem_w_enb  = d_oor ? 4'b0000 : bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_gnt;
      if (i_gnt) begin
        i_rdata_q <= i_oor ? 32'd0 : bus.mem_r_data;
        i_err_q   <= i_oor;
      end
      if (d_gnt) begin
        d_rdata_q <= (d_oor || !d_is_read) ? 32'd0 : bus.mem_r_data;
        d_err_q   <= d_oor;
      end
    end
  end

  // a reset landing in the response cycle must swallow that response
  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid_q && !rst;
  assign bus.d_rvalid = d_rvalid_q && !rst;
  assign bus.i_rdata  = rst ? 32'd0 : i_rdata_q;
  assign bus.d_rdata  = rst ? 32'd0 : d_rdata_q;
  assign bus.i_err    = i_err_q && !rst;
  assign bus.d_err    = d_err_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a 1 KiB byte memory model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.ADDR_BITS(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  mem [0:1023];
  logic        bd_fill = 1'b0;
  logic        bd_en = 1'b0;
  logic [9:0]  bd_addr = 10'd0;
  logic [31:0] bd_data = 32'd0;
  logic [9:0]  ra;

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int j = 0; j < 1024; j++) mem[j] <= 8'hFF;
    end else begin
      if (bd_en)
        for (int k = 0; k < 4; k++) mem[bd_addr + 10'(k)] <= bd_data[8*k +: 8];
      for (int k = 0; k < 4; k++)
        if (bus.mem_w_enb[k]) mem[bus.mem_addr[9:0] + 10'(k)] <= bus.mem_w_data[8*k +: 8];
    end
  end

  always_comb begin
    ra = bus.mem_addr[9:0];
    bus.mem_r_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
  end

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  task automatic idle();
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 4'b0000; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk); bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1 bd_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 32'h20;
    #1;
    total++; if (bus.i_gnt !== 1'b0) begin bad++; $display("FAIL rst_i_gnt got=%h exp=0", bus.i_gnt); end
    total++; if (bus.d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt got=%h exp=0", bus.d_gnt); end
    total++; if (bus.mem_w_enb !== 4'h0) begin bad++; $display("FAIL rst_mem_w_enb got=%h exp=0", bus.mem_w_enb); end
    total++; if (bus.mem_r_enb !== 1'b0) begin bad++; $display("FAIL rst_mem_r_enb got=%h exp=0", bus.mem_r_enb); end
    @(posedge clk); #1;
    total++; if (bus.i_rvalid !== 1'b0) begin bad++; $display("FAIL rst_i_rvalid got=%h exp=0", bus.i_rvalid); end
    total++; if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_d_rvalid got=%h exp=0", bus.d_rvalid); end
    total++; if (bus.i_rdata !== 32'd0) begin bad++; $display("FAIL rst_i_rdata got=%h exp=0", bus.i_rdata); end
    total++; if (bus.d_rdata !== 32'd0) begin bad++; $display("FAIL rst_d_rdata got=%h exp=0", bus.d_rdata); end
    total++; if ({bus.i_err, bus.d_err} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {bus.i_err, bus.d_err}); end
    idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fetch();
    bd_write(10'h10, 32'hDEAD_BEEF);
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h10;
    #1;
    total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL fetch_i_gnt got=%h exp=1", bus.i_gnt); end
    total++; if (bus.d_gnt !== 1'b0) begin bad++; $display("FAIL fetch_d_gnt got=%h exp=0", bus.d_gnt); end
    total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_mem_addr got=%h exp=10", bus.mem_addr); end
    total++; if (bus.mem_r_enb !== 1'b1) begin bad++; $display("FAIL fetch_mem_r_enb got=%h exp=1", bus.mem_r_enb); end
    total++; if (bus.mem_w_enb !== 4'h0) begin bad++; $display("FAIL fetch_mem_w_enb got=%h exp=0", bus.mem_w_enb); end
    @(posedge clk); #1 idle();
    total++; if (bus.i_rvalid !== 1'b1) begin bad++; $display("FAIL fetch_i_rvalid got=%h exp=1", bus.i_rvalid); end
    total++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_i_rdata got=%h exp=deadbeef", bus.i_rdata); end
    total++; if (bus.i_err !== 1'b0) begin bad++; $display("FAIL fetch_i_err got=%h exp=0", bus.i_err); end
    total++; if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_d_rvalid got=%h exp=0", bus.d_rvalid); end
    @(posedge clk); #1;
    total++; if (bus.i_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_i_rvalid_drop got=%h exp=0", bus.i_rvalid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    #1;
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL st_d_gnt got=%h exp=1", bus.d_gnt); end
    total++; if (bus.mem_w_enb !== 4'b0011) begin bad++; $display("FAIL st_mem_w_enb got=%h exp=3", bus.mem_w_enb); end
    total++; if (bus.mem_r_enb !== 1'b0) begin bad++; $display("FAIL st_mem_r_enb got=%h exp=0", bus.mem_r_enb); end
    total++; if (bus.mem_w_data !== 32'h1234_5678) begin bad++; $display("FAIL st_mem_w_data got=%h exp=12345678", bus.mem_w_data); end
    @(posedge clk); #1;
    total++; if (bus.d_rvalid !== 1'b1) begin bad++; $display("FAIL st_d_rvalid got=%h exp=1", bus.d_rvalid); end
    total++; if (bus.d_rdata !== 32'd0) begin bad++; $display("FAIL st_d_rdata got=%h exp=0", bus.d_rdata); end
    total++; if (bus.d_err !== 1'b0) begin bad++; $display("FAIL st_d_err got=%h exp=0", bus.d_err); end
    bus.d_we = 4'b0000;
    #1;
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL ld_d_gnt got=%h exp=1", bus.d_gnt); end
    @(posedge clk); #1 idle();
    total++; if (bus.d_rvalid !== 1'b1) begin bad++; $display("FAIL ld_d_rvalid got=%h exp=1", bus.d_rvalid); end
    total++; if (bus.d_rdata !== 32'hFFFF_5678) begin bad++; $display("FAIL ld_d_rdata got=%h exp=ffff5678", bus.d_rdata); end
    total++; if (bus.d_err !== 1'b0) begin bad++; $display("FAIL ld_d_err got=%h exp=0", bus.d_err); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_d;
`ifdef MEM_ARB_DPRIO_EN
    exp_d = 4'b1111;
`else
    exp_d = 4'b0101;
`endif
    do_reset();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h20;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (bus.d_gnt !== exp_d[c]) begin bad++; $display("FAIL cont_d_gnt[%0d] got=%h exp=%h", c, bus.d_gnt, exp_d[c]); end
      total++; if (bus.i_gnt !== !exp_d[c]) begin bad++; $display("FAIL cont_i_gnt[%0d] got=%h exp=%h", c, bus.i_gnt, !exp_d[c]); end
      if (c > 0) begin
        total++; if (bus.d_rvalid !== exp_d[c-1]) begin bad++; $display("FAIL cont_d_rvalid[%0d] got=%h exp=%h", c, bus.d_rvalid, exp_d[c-1]); end
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_range();
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h0000_03FD;
    bad_addr[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 32'h3FE; bus.d_wdata = 32'hA5A5_A5A5;
    #1;
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL rng_d_gnt got=%h exp=1", bus.d_gnt); end
    total++; if (bus.mem_w_enb !== 4'h0) begin bad++; $display("FAIL rng_mem_w_enb got=%h exp=0", bus.mem_w_enb); end
    total++; if (bus.mem_r_enb !== 1'b0) begin bad++; $display("FAIL rng_mem_r_enb got=%h exp=0", bus.mem_r_enb); end
    @(posedge clk); #1 idle();
    total++; if (bus.d_rvalid !== 1'b1) begin bad++; $display("FAIL rng_d_rvalid got=%h exp=1", bus.d_rvalid); end
    total++; if (bus.d_err !== 1'b1) begin bad++; $display("FAIL rng_d_err got=%h exp=1", bus.d_err); end
    total++; if (bus.d_rdata !== 32'd0) begin bad++; $display("FAIL rng_d_rdata got=%h exp=0", bus.d_rdata); end
    total++; if (mem_word(10'h3FC) !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rng_mem_kept got=%h exp=ffffffff", mem_word(10'h3FC)); end
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h3FC;
    #1;
    total++; if (bus.mem_r_enb !== 1'b1) begin bad++; $display("FAIL rng_top_r_enb got=%h exp=1", bus.mem_r_enb); end
    @(posedge clk); #1 idle();
    total++; if (bus.i_rvalid !== 1'b1) begin bad++; $display("FAIL rng_top_i_rvalid got=%h exp=1", bus.i_rvalid); end
    total++; if (bus.i_err !== 1'b0) begin bad++; $display("FAIL rng_top_i_err got=%h exp=0", bus.i_err); end
    total++; if (bus.i_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rng_top_i_rdata got=%h exp=ffffffff", bus.i_rdata); end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); bus.i_req = 1'b1; bus.i_addr = bad_addr[n];
      #1;
      total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL rng_oor_i_gnt[%0d] got=%h exp=1", n, bus.i_gnt); end
      total++; if (bus.mem_r_enb !== 1'b0) begin bad++; $display("FAIL rng_oor_r_enb[%0d] got=%h exp=0", n, bus.mem_r_enb); end
      @(posedge clk); #1 idle();
      total++; if (bus.i_err !== 1'b1) begin bad++; $display("FAIL rng_oor_i_err[%0d] got=%h exp=1", n, bus.i_err); end
      total++; if (bus.i_rdata !== 32'd0) begin bad++; $display("FAIL rng_oor_i_rdata[%0d] got=%h exp=0", n, bus.i_rdata); end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h10;
    #1;
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL mid_d_gnt got=%h exp=1", bus.d_gnt); end
    @(posedge clk); #1 idle(); rst = 1'b1;
    #1;
    total++; if (bus.d_rvalid !== 1'b0) begin bad++; $display("FAIL mid_d_rvalid got=%h exp=0", bus.d_rvalid); end
    total++; if (bus.d_rdata !== 32'd0) begin bad++; $display("FAIL mid_d_rdata got=%h exp=0", bus.d_rdata); end
    total++; if ({bus.i_rvalid, bus.i_err, bus.d_err} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b exp=000", {bus.i_rvalid, bus.i_err, bus.d_err}); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.d_req = 1'b1; bus.d_addr = 32'h10;
    #1;
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL mid_tie_d_gnt got=%h exp=1", bus.d_gnt); end
    total++; if (bus.i_gnt !== 1'b0) begin bad++; $display("FAIL mid_tie_i_gnt got=%h exp=0", bus.i_gnt); end
    @(posedge clk); #1 idle();
    total++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_tie_d_rdata got=%h exp=deadbeef", bus.d_rdata); end
    total++; if (bus.i_rvalid !== 1'b0) begin bad++; $display("FAIL mid_tie_i_rvalid got=%h exp=0", bus.i_rvalid); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    bd_fill = 1'b1;
    @(posedge clk); #1 bd_fill = 1'b0;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_contention();
    test_range();
    test_reset_midop();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
